// File: rtl/wb_port_arb_if.sv
// wb_port_arb_if: groups the pipeline writeback request, the LLU result
// handshake and the register-file write port behind the writeback stage.
// DEPTH must match the DEPTH of the wb_port_arb instance it connects to;
// it sizes the occupancy output.
interface wb_port_arb_if #(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wb_valid_i;
    logic [4:0]       wb_waddr_i;
    logic [31:0]      wb_wdata_i;
    logic             llu_valid_i;
    logic [4:0]       llu_waddr_i;
    logic [31:0]      llu_wdata_i;
    logic             llu_ready_o;
    logic             rf_we_o;
    logic [4:0]       rf_waddr_o;
    logic [31:0]      rf_wdata_o;
    logic             stall_o;
    logic [CNT_W-1:0] fifo_cnt_o;

    // Requester side: pipeline writeback plus LLU, observing the RF port.
    modport master (
        output wb_valid_i, wb_waddr_i, wb_wdata_i,
        output llu_valid_i, llu_waddr_i, llu_wdata_i,
        input  llu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_o, fifo_cnt_o
    );

    // Arbiter side.
    modport slave (
        input  wb_valid_i, wb_waddr_i, wb_wdata_i,
        input  llu_valid_i, llu_waddr_i, llu_wdata_i,
        output llu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, stall_o, fifo_cnt_o
    );
endinterface

// File: rtl/wb_port_arb.sv
// wb_port_arb: owns the single register-file write port. Pipeline writes
// always win; long-latency-unit results queue in a DEPTH-entry FIFO and
// drain into free slots in arrival order. Writes to x0 never reach the RF.
// Optional feature macro: WB_ARB_STARVE_EN adds a starvation guard that
// raises stall_o for one cycle when the FIFO head has waited too long.
module wb_port_arb #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    wb_port_arb_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_port_arb: DEPTH must be a power of two >= 2");
    end
    if (STARVE_MAX < 2) begin : g_bad_starve
        $error("wb_port_arb: STARVE_MAX must be >= 2");
    end

    logic [36:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             pipe_win;
    logic             push;
    logic             pop;
    logic [4:0]       head_waddr;
    logic [31:0]      head_wdata;

    assign {head_waddr, head_wdata} = mem_q[rd_ptr_q];

    // Ready depends only on the current occupancy, so a same-cycle pop never raises it.
    assign bus.llu_ready_o = (count_q < DEPTH_C);
    assign bus.fifo_cnt_o  = count_q;
    assign bus.rf_we_o     = rf_we_q;
    assign bus.rf_waddr_o  = rf_waddr_q;
    assign bus.rf_wdata_o  = rf_wdata_q;

    // Arbitrate the write slot and compute next FIFO bookkeeping and RF port values.
    always_comb begin
        pipe_win   = bus.wb_valid_i && (bus.wb_waddr_i != 5'd0);
        pop        = !pipe_win && (count_q != '0);
        push       = bus.llu_valid_i && (count_q < DEPTH_C);
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_win) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.wb_waddr_i;
            rf_wdata_d = bus.wb_wdata_i;
        end else if (pop && head_waddr != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_waddr;
            rf_wdata_d = head_wdata;
        end
    end

    // FIFO storage is deliberately left unreset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.llu_waddr_i, bus.llu_wdata_i};
        end
    end

    // Control state and registered RF port; reset discards any queued results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef WB_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX) + 1;

    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    // Count cycles the head waits; the cycle it would reach STARVE_MAX-1 requests a one-cycle stall.
    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (pop || count_q == '0) begin
            starve_d = '0;
        end else if (starve_q == SW'(STARVE_MAX - 2)) begin
            starve_d = '0;
            stall_d  = 1'b1;
        end else begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Starvation counter and registered stall request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.stall_o = stall_q;
`else
    assign bus.stall_o = 1'b0;
`endif
endmodule
